alu_issue: RTL and testbench

Two-stage issue/retire wrapper that drives the datapath ALU's `op`/`rs1`/`rs2` ports and collects its `rd`/`zero`/`overflow` results. It accepts R-type and branch/memory-class requests over a valid/ready handshake and decodes MIPS ALUOp/funct into the ALU's 4-bit op code. It registers operands into an issue stage, captures the ALU result into a retire stage, and presents the result downstream with backpressure. It also counts overflowing operations.

---
 rtl/alu_issue.sv | 153 +++++++++++++++
 tb/tb_alu_issue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Two-stage issue/retire wrapper around a combinational ALU: decodes MIPS ALUOp/funct,
// registers operands for issue, captures results at retire, counts overflows (saturating).
module alu_issue #(
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_aluop,
    input  logic [5:0]        in_funct,
    input  logic [DWIDTH-1:0] in_a,
    input  logic [DWIDTH-1:0] in_b,
    output logic [3:0]        alu_op,
    output logic [DWIDTH-1:0] alu_rs1,
    output logic [DWIDTH-1:0] alu_rs2,
    input  logic [DWIDTH-1:0] alu_rd,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_rd,
    output logic              out_zero,
    output logic              out_overflow,
    output logic              out_illegal,
    output logic [CWIDTH-1:0] ovf_count
);

    logic [3:0]        dec_op;
    logic              dec_illegal;

    logic              s1_valid_reg;
    logic [3:0]        s1_op_reg;
    logic              s1_illegal_reg;
    logic [DWIDTH-1:0] s1_a_reg;
    logic [DWIDTH-1:0] s1_b_reg;

    logic              out_valid_reg;
    logic [DWIDTH-1:0] out_rd_reg;
    logic              out_zero_reg;
    logic              out_overflow_reg;
    logic              out_illegal_reg;
    logic [CWIDTH-1:0] ovf_count_reg;

    logic [DWIDTH-1:0] s2_rd_next;
    logic              s2_zero_next;
    logic              s2_overflow_next;

    logic              adv2;
    logic              in_fire;
    logic              s2_load;
    logic              out_fire;

    always_comb begin
        dec_op      = 4'b1111;
        dec_illegal = 1'b1;
        case (in_aluop)
            2'b00: begin dec_op = 4'b0010; dec_illegal = 1'b0; end
            2'b01: begin dec_op = 4'b0110; dec_illegal = 1'b0; end
            2'b10: begin
                dec_illegal = 1'b0;
                case (in_funct)
                    6'b100000: dec_op = 4'b0010;
                    6'b100010: dec_op = 4'b0110;
                    6'b100100: dec_op = 4'b0000;
                    6'b100101: dec_op = 4'b0001;
                    6'b100111: dec_op = 4'b1100;
                    6'b101010: dec_op = 4'b0111;
                    default: begin
                        dec_op      = 4'b1111;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_op      = 4'b1111;
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign adv2     = ~out_valid_reg | out_ready;
    assign in_ready = ~s1_valid_reg | adv2;
    assign in_fire  = in_valid & in_ready;
    assign s2_load  = s1_valid_reg & adv2;
    assign out_fire = out_valid_reg & out_ready;

    // Illegal ops retire as all-zero results no matter what the ALU produced.
    genvar gi;
    generate
        for (gi = 0; gi < DWIDTH; gi++) begin : g_rd_mask
            assign s2_rd_next[gi] = alu_rd[gi] & ~s1_illegal_reg;
        end
    endgenerate
    assign s2_zero_next     = alu_zero & ~s1_illegal_reg;
    assign s2_overflow_next = alu_overflow & ~s1_illegal_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_op_reg      <= 4'b0000;
            s1_illegal_reg <= 1'b0;
            s1_a_reg       <= '0;
            s1_b_reg       <= '0;
        end else if (in_fire) begin
            s1_valid_reg   <= 1'b1;
            s1_op_reg      <= dec_op;
            s1_illegal_reg <= dec_illegal;
            s1_a_reg       <= in_a;
            s1_b_reg       <= in_b;
        end else if (s2_load) begin
            s1_valid_reg   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg    <= 1'b0;
            out_rd_reg       <= '0;
            out_zero_reg     <= 1'b0;
            out_overflow_reg <= 1'b0;
            out_illegal_reg  <= 1'b0;
        end else if (s2_load) begin
            out_valid_reg    <= 1'b1;
            out_rd_reg       <= s2_rd_next;
            out_zero_reg     <= s2_zero_next;
            out_overflow_reg <= s2_overflow_next;
            out_illegal_reg  <= s1_illegal_reg;
        end else if (out_fire) begin
            out_valid_reg    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_reg <= '0;
        end else if (out_fire && out_overflow_reg && (ovf_count_reg != {CWIDTH{1'b1}})) begin
            ovf_count_reg <= ovf_count_reg + 1'b1;
        end
    end

    assign alu_op       = s1_op_reg;
    assign alu_rs1      = s1_a_reg;
    assign alu_rs2      = s1_b_reg;
    assign out_valid    = out_valid_reg;
    assign out_rd       = out_rd_reg;
    assign out_zero     = out_zero_reg;
    assign out_overflow = out_overflow_reg;
    assign out_illegal  = out_illegal_reg;
    assign ovf_count    = ovf_count_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a behavioural ALU closes the loop, a second instance
// with a 2-bit counter exercises overflow-count saturation on the same stimulus.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready_s;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic [31:0] in_a, in_b;
    logic        out_ready;

    logic [3:0]  alu_op, alu_op_s;
    logic [31:0] alu_rs1, alu_rs2, alu_rs1_s, alu_rs2_s;
    logic [31:0] alu_rd, alu_rd_s;
    logic        alu_zero, alu_zero_s, alu_overflow, alu_overflow_s;

    logic        out_valid, out_valid_s;
    logic [31:0] out_rd, out_rd_s;
    logic        out_zero, out_overflow, out_illegal;
    logic        out_zero_s, out_overflow_s, out_illegal_s;
    logic [15:0] ovf_count;
    logic [1:0]  ovf_count_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Reference ALU; unknown ops give a nonzero result so retire masking is visible.
    function automatic logic [33:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            4'b0010: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0110: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0111: r = {31'd0, $signed(a) < $signed(b)};
            default: r = a ^ b ^ 32'hDEAD_BEEF;
        endcase
        return {v, (r == 32'd0), r};
    endfunction

    assign {alu_overflow, alu_zero, alu_rd}       = alu_f(alu_op, alu_rs1, alu_rs2);
    assign {alu_overflow_s, alu_zero_s, alu_rd_s} = alu_f(alu_op_s, alu_rs1_s, alu_rs2_s);

    alu_issue #(.DWIDTH(32), .CWIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
        .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_rd(alu_rd), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_zero(out_zero), .out_overflow(out_overflow), .out_illegal(out_illegal),
        .ovf_count(ovf_count)
    );

    alu_issue #(.DWIDTH(32), .CWIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_aluop(in_aluop), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
        .alu_op(alu_op_s), .alu_rs1(alu_rs1_s), .alu_rs2(alu_rs2_s),
        .alu_rd(alu_rd_s), .alu_zero(alu_zero_s), .alu_overflow(alu_overflow_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_rd(out_rd_s),
        .out_zero(out_zero_s), .out_overflow(out_overflow_s), .out_illegal(out_illegal_s),
        .ovf_count(ovf_count_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = 1'b1;
        in_aluop = op;
        in_funct = fn;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_aluop = 2'b00; in_funct = 6'd0;
        in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;
        #1;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_rs1", alu_rs1, 0);
        check("rst_alu_rs2", alu_rs2, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_flags", {out_zero, out_overflow, out_illegal}, 0);
        check("rst_ovf_count", ovf_count, 0);

        // Single ADD 5+7
        issue(2'b10, 6'b100000, 32'd5, 32'd7);
        tick(); idle();
        check("add_alu_op", alu_op, 4'b0010);
        check("add_alu_rs1", alu_rs1, 5);
        check("add_alu_rs2", alu_rs2, 7);
        check("add_not_yet_valid", out_valid, 0);
        tick();
        check("add_out_valid", out_valid, 1);
        check("add_out_rd", out_rd, 12);
        check("add_flags", {out_zero, out_overflow, out_illegal}, 0);
        $display("[TB] ADD 5+7 -> %0d", out_rd);
        tick();
        check("add_drained", out_valid, 0);

        // Back-to-back stream
        issue(2'b01, 6'b000000, 32'd9, 32'd9);                   tick();
        issue(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);   tick();
        check("sub_rd", out_rd, 0);
        check("sub_zero", out_zero, 1);
        $display("[TB] SUB 9-9 -> %0h", out_rd);
        issue(2'b10, 6'b100111, 32'd0, 32'd0);                   tick();
        check("and_valid", out_valid, 1);
        check("and_rd", out_rd, 32'h00F0_00F0);
        $display("[TB] AND -> %0h", out_rd);
        issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);           tick(); idle();
        check("nor_rd", out_rd, 32'hFFFF_FFFF);
        check("nor_zero", out_zero, 0);
        $display("[TB] NOR -> %0h", out_rd);
        tick();
        check("slt_valid", out_valid, 1);
        check("slt_rd", out_rd, 1);
        $display("[TB] SLT -> %0h", out_rd);
        tick();
        check("stream_drained", out_valid, 0);

        // Overflowing ADD
        issue(2'b00, 6'b000000, 32'h7FFF_FFFF, 32'd1); tick(); idle(); tick();
        check("ovf_flag", out_overflow, 1);
        check("ovf_zero", out_zero, 0);
        check("ovf_rd", out_rd, 32'h8000_0000);
        check("ovf_count_pre", ovf_count, 0);
        tick();
        check("ovf_count_1", ovf_count, 1);
        check("sat_count_1", ovf_count_s, 1);
        $display("[TB] ADD ovf -> count=%0d sat=%0d", ovf_count, ovf_count_s);

        // Saturation on the 2-bit counter
        for (int k = 2; k <= 5; k++) begin
            issue(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h7FFF_FFFF); tick(); idle(); tick(); tick();
            check("ovf_count_k", ovf_count, k);
            check("sat_count_k", ovf_count_s, (k < 3) ? k : 3);
            $display("[TB] ADD ovf #%0d -> count=%0d sat=%0d", k, ovf_count, ovf_count_s);
        end

        // Backpressure
        out_ready = 1'b0;
        issue(2'b00, 6'd0, 32'd1, 32'd2); tick();
        issue(2'b00, 6'd0, 32'd3, 32'd4); tick();
        issue(2'b00, 6'd0, 32'd10, 32'd20);
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_out_rd", out_rd, 3);
            check("bp_alu_rs1", alu_rs1, 3);
            check("bp_alu_rs2", alu_rs2, 4);
            $display("[TB] stall cycle %0d out_rd=%0d", c, out_rd);
            tick();
        end
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        tick(); idle();
        check("bp_drain1", out_rd, 7);
        check("bp_new_issue", alu_rs1, 10);
        $display("[TB] drain -> %0d", out_rd);
        tick();
        check("bp_drain2", out_rd, 30);
        check("bp_drain2_valid", out_valid, 1);
        $display("[TB] drain -> %0d", out_rd);
        tick();
        check("bp_empty", out_valid, 0);

        // Illegal requests
        issue(2'b10, 6'b000000, 32'd5, 32'd6); tick();
        check("ill1_alu_op", alu_op, 4'b1111);
        issue(2'b11, 6'b100000, 32'd1, 32'd2); tick(); idle();
        check("ill1_illegal", out_illegal, 1);
        check("ill1_rd", out_rd, 0);
        check("ill1_zero", out_zero, 0);
        check("ill2_alu_op", alu_op, 4'b1111);
        $display("[TB] illegal funct -> illegal=%0d rd=%0h", out_illegal, out_rd);
        tick();
        check("ill2_valid", out_valid, 1);
        check("ill2_flags", {out_illegal, out_zero, out_overflow}, 3'b100);
        check("ill2_rd", out_rd, 0);
        $display("[TB] ALUOp 11 -> illegal=%0d rd=%0h", out_illegal, out_rd);
        tick();

        // Reset with both stages full
        out_ready = 1'b0;
        issue(2'b00, 6'd0, 32'd1, 32'd1); tick();
        issue(2'b00, 6'd0, 32'd2, 32'd2); tick(); idle();
        check("full_in_ready", in_ready, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_ovf_count", ovf_count, 0);
        out_ready = 1'b1;
        tick();
        check("mid_rst_no_emit", out_valid, 0);
        $display("[TB] reset mid-flight -> out_valid=%0d in_ready=%0d", out_valid, in_ready);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
